// File: rtl/hdmi_timing_pkg.sv
// Shared definitions for the HDMI video timing controller.
//   - vt_state_e      : run-control state encoding
//   - C_* constants   : 24-bit {R,G,B} colours of the test colour bars
//   - DEF_* constants : default 640x480@60 timing
//   - bar_colour()    : colour of bar 0..7, left to right
package hdmi_timing_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } vt_state_e;

   localparam int CNT_W   = 12;
   localparam int CNT_MAX = 4096;

   localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] C_CYAN    = 24'h00FFFF;
   localparam logic [23:0] C_GREEN   = 24'h00FF00;
   localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] C_RED     = 24'hFF0000;
   localparam logic [23:0] C_BLUE    = 24'h0000FF;
   localparam logic [23:0] C_BLACK   = 24'h000000;

   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = C_WHITE;
         3'd1:    c = C_YELLOW;
         3'd2:    c = C_CYAN;
         3'd3:    c = C_GREEN;
         3'd4:    c = C_MAGENTA;
         3'd5:    c = C_RED;
         3'd6:    c = C_BLUE;
         default: c = C_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical position counters with region decode.
//   clk, rst            : clock, async active-high reset
//   run                 : 1 = free-run, 0 = hold both counters at zero
//   h_cnt, v_cnt        : current position (regions: sync, back porch, active, front porch)
//   h_sync_act/v_sync_act : position lies in the sync region of that axis
//   h_active/v_active   : position lies in the active region of that axis
//   frame_last          : last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1)
module video_timing_cnt
   import hdmi_timing_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             h_sync_act,
   output logic             v_sync_act,
   output logic             h_active,
   output logic             v_active,
   output logic             frame_last
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   // region bounds can reach 4096, so compare one bit wider than the counters
   localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_SYNC);
   localparam logic [CNT_W:0] HA_BEG = (CNT_W+1)'(H_SYNC + H_BACK);
   localparam logic [CNT_W:0] HA_END = (CNT_W+1)'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_SYNC);
   localparam logic [CNT_W:0] VA_BEG = (CNT_W+1)'(V_SYNC + V_BACK);
   localparam logic [CNT_W:0] VA_END = (CNT_W+1)'(V_SYNC + V_BACK + V_ACTIVE);

   logic h_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   assign h_last     = (h_cnt == H_LAST);
   assign frame_last = h_last && (v_cnt == V_LAST);
   assign h_sync_act = ({1'b0, h_cnt} < HS_END);
   assign v_sync_act = ({1'b0, v_cnt} < VS_END);
   assign h_active   = ({1'b0, h_cnt} >= HA_BEG) && ({1'b0, h_cnt} < HA_END);
   assign v_active   = ({1'b0, v_cnt} >= VA_BEG) && ({1'b0, v_cnt} < VA_END);

endmodule

// File: rtl/hdmi_video_timing.sv
// HDMI video timing controller: generates hsync/vsync/DE and pixel requests,
// registers the returned RGB so all outputs leave mutually aligned.
//   vga_clk, sys_rst      : pixel clock, async active-high reset
//   enable                : run request; start/stop take effect on frame boundaries
//   pix_data_in           : {R,G,B} answer to pix_req, captured on the edge that
//                           closes the pix_req cycle
//   pix_req, pix_x, pix_y : stage-1 pixel request and its active column/row
//   hsync, vsync, rgb_valid, rgb_red/green/blue, frame_start : stage-2 outputs
// Optional feature macro HDMI_COLORBAR_EN: replace pix_data_in with an
// internal 8-bar colour pattern (pix_req is still driven).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | counters held at 0, outputs inactive
// RUN       | counters free-run, video generated
// STOP_PEND | stop requested, finishing the current frame
module hdmi_video_timing
   import hdmi_timing_pkg::*;
#(
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BACK   = DEF_H_BACK,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FRONT  = DEF_H_FRONT,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BACK   = DEF_V_BACK,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FRONT  = DEF_V_FRONT,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic        enable,
   input  logic [23:0] pix_data_in,
   output logic        pix_req,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic        rgb_valid,
   output logic [7:0]  rgb_red,
   output logic [7:0]  rgb_green,
   output logic [7:0]  rgb_blue,
   output logic        frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam logic [11:0] HA_BEG = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] VA_BEG = 12'(V_SYNC + V_BACK);

   if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_check
      $error("hdmi_video_timing: H_TOTAL/V_TOTAL must not exceed 4096");
   end

   vt_state_e   state_q, state_d;
   logic        running;
   logic [11:0] h_cnt, v_cnt;
   logic        h_sync_act, v_sync_act, h_active, v_active, frame_last;
   logic        hs_s1, vs_s1, fs_s1;
   logic [23:0] src_rgb, rgb_q;

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // A stop that coincides with the last pixel goes straight to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (enable) state_d = RUN;
         RUN:       if (!enable) state_d = frame_last ? IDLE : STOP_PEND;
         STOP_PEND: begin
            if (enable)          state_d = RUN;
            else if (frame_last) state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   assign running = (state_q != IDLE);

   video_timing_cnt #(
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
   ) u_cnt (
      .clk        (vga_clk),
      .rst        (sys_rst),
      .run        (running),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .h_sync_act (h_sync_act),
      .v_sync_act (v_sync_act),
      .h_active   (h_active),
      .v_active   (v_active),
      .frame_last (frame_last)
   );

   // Stage 1: request and sync levels for the current counter position.
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pix_req <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
         hs_s1   <= ~HS_POL;
         vs_s1   <= ~VS_POL;
         fs_s1   <= 1'b0;
      end else begin
         pix_req <= running && h_active && v_active;
         pix_x   <= (running && h_active && v_active) ? h_cnt - HA_BEG : '0;
         pix_y   <= (running && h_active && v_active) ? v_cnt - VA_BEG : '0;
         hs_s1   <= (running && h_sync_act) ? HS_POL : ~HS_POL;
         vs_s1   <= (running && v_sync_act) ? VS_POL : ~VS_POL;
         fs_s1   <= running && (h_cnt == '0) && (v_cnt == '0);
      end
   end

`ifdef HDMI_COLORBAR_EN
   localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
   logic [11:0] bar_num;
   logic        unused_pix_data;
   assign bar_num         = pix_x / 12'(BAR_W);
   // bars past the seventh (remainder pixels) stay on the last bar
   assign src_rgb         = bar_colour((bar_num > 12'd7) ? 3'd7 : bar_num[2:0]);
   assign unused_pix_data = ^pix_data_in;
`else
   assign src_rgb = pix_data_in;
`endif

   // Stage 2: capture the source answer and delay sync/DE to match.
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         rgb_valid   <= 1'b0;
         frame_start <= 1'b0;
         rgb_q       <= '0;
      end else begin
         hsync       <= hs_s1;
         vsync       <= vs_s1;
         rgb_valid   <= pix_req;
         frame_start <= fs_s1;
         rgb_q       <= pix_req ? src_rgb : '0;
      end
   end

   assign rgb_red   = rgb_q[23:16];
   assign rgb_green = rgb_q[15:8];
   assign rgb_blue  = rgb_q[7:0];

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Self-checking bench for hdmi_video_timing using a reduced timing set
// (27 x 11 total, 18 x 6 active) so that many frames fit in a short run.
// Expected outputs come from a closed-form position model indexed by the
// cycle at which enable was sampled; returned RGB is checked via a queue.
module tb_hdmi_video_timing;

   localparam int H_SY = 4, H_BP = 3, H_AC = 18, H_FP = 2;
   localparam int V_SY = 2, V_BP = 2, V_AC = 6,  V_FP = 1;
   localparam int HT = H_SY + H_BP + H_AC + H_FP;
   localparam int VT = V_SY + V_BP + V_AC + V_FP;
   localparam int FT = HT * VT;
   localparam logic HPOL = 1'b0, VPOL = 1'b0;
   localparam longint INF = 64'sh3fff_ffff_ffff_ffff;

   logic        vga_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] pix_data_in = '0;
   logic        pix_req, hsync, vsync, rgb_valid, frame_start;
   logic [11:0] pix_x, pix_y;
   logic [7:0]  rgb_red, rgb_green, rgb_blue;

   hdmi_video_timing #(
      .H_SYNC(H_SY), .H_BACK(H_BP), .H_ACTIVE(H_AC), .H_FRONT(H_FP),
      .V_SYNC(V_SY), .V_BACK(V_BP), .V_ACTIVE(V_AC), .V_FRONT(V_FP),
      .HS_POL(HPOL), .VS_POL(VPOL)
   ) dut (
      .vga_clk(vga_clk), .sys_rst(sys_rst), .enable(enable), .pix_data_in(pix_data_in),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
      .rgb_valid(rgb_valid), .rgb_red(rgb_red), .rgb_green(rgb_green),
      .rgb_blue(rgb_blue), .frame_start(frame_start)
   );

   always #5 vga_clk = ~vga_clk;

   longint cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // model: run started by the edge at which cyc became m_k, last counter index m_end
   bit     m_on  = 1'b0;
   longint m_k   = 0;
   longint m_end = INF;
   logic [23:0] exp_q[$];

   typedef struct packed {
      logic        req;
      logic [11:0] x;
      logic [11:0] y;
      logic        hs;
      logic        vs;
      logic        fs;
   } exp_t;

   function automatic exp_t expect_at(longint n);
      exp_t   e;
      longint h, v;
      e.req = 1'b0; e.x = '0; e.y = '0; e.hs = ~HPOL; e.vs = ~VPOL; e.fs = 1'b0;
      if (m_on && n >= 0 && n <= m_end) begin
         h = n % HT;
         v = (n / HT) % VT;
         e.hs = (h < H_SY) ? HPOL : ~HPOL;
         e.vs = (v < V_SY) ? VPOL : ~VPOL;
         e.fs = (h == 0 && v == 0);
         if (h >= H_SY + H_BP && h < H_SY + H_BP + H_AC &&
             v >= V_SY + V_BP && v < V_SY + V_BP + V_AC) begin
            e.req = 1'b1;
            e.x   = 12'(h - H_SY - H_BP);
            e.y   = 12'(v - V_SY - V_BP);
         end
      end
      return e;
   endfunction

   function automatic logic [23:0] src_expect(logic [11:0] x, logic [11:0] y);
`ifdef HDMI_COLORBAR_EN
      int b;
      b = int'(x) / (H_AC / 8);
      if (b > 7) b = 7;
      case (b)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000 | {24{y[0] & 1'b0}};
      endcase
`else
      return {x[7:0], y[7:0], 8'hA5};
`endif
   endfunction

   // pixel source: answers each request before the next edge, garbage otherwise
   exp_t src_e;
   initial begin
      forever begin
         @(posedge vga_clk);
         #1;
         src_e = expect_at(cyc - m_k - 1);
         if (!sys_rst && src_e.req) exp_q.push_back(src_expect(src_e.x, src_e.y));
         if (pix_req === 1'b1) pix_data_in = {pix_x[7:0], pix_y[7:0], 8'hA5};
         else                  pix_data_in = 24'($urandom);
      end
   end

   // cycle monitor / scoreboard consumer
   exp_t        e1, e2;
   logic [23:0] rgb_exp, rgb_act;
   always @(negedge vga_clk) begin
      if (!sys_rst) begin
         e1 = expect_at(cyc - m_k - 1);
         e2 = expect_at(cyc - m_k - 2);
         rgb_act = {rgb_red, rgb_green, rgb_blue};
         cmp_cnt++;
         if ({pix_req, pix_x, pix_y} !== {e1.req, e1.x, e1.y}) begin
            err_cnt++;
            $display("FAIL stage1 cyc=%0d got req=%b x=%0d y=%0d want req=%b x=%0d y=%0d",
                     cyc, pix_req, pix_x, pix_y, e1.req, e1.x, e1.y);
         end
         cmp_cnt++;
         if ({hsync, vsync, rgb_valid, frame_start} !== {e2.hs, e2.vs, e2.req, e2.fs}) begin
            err_cnt++;
            $display("FAIL stage2 cyc=%0d got hs=%b vs=%b de=%b fs=%b want hs=%b vs=%b de=%b fs=%b",
                     cyc, hsync, vsync, rgb_valid, frame_start, e2.hs, e2.vs, e2.req, e2.fs);
         end
         cmp_cnt++;
         if (rgb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL rgb_underflow cyc=%0d got rgb=%06h want no rgb_valid", cyc, rgb_act);
            end else begin
               rgb_exp = exp_q.pop_front();
               if (rgb_act !== rgb_exp) begin
                  err_cnt++;
                  $display("FAIL rgb_data cyc=%0d got %06h want %06h", cyc, rgb_act, rgb_exp);
               end
            end
         end else if (rgb_act !== 24'h0) begin
            err_cnt++;
            $display("FAIL rgb_blank cyc=%0d got %06h want 000000", cyc, rgb_act);
         end
      end
   end

   // drive helpers (called at a negedge; the next posedge samples)
   task automatic start_run();
      enable = 1'b1; m_k = cyc + 1; m_end = INF; m_on = 1'b1;
   endtask

   task automatic drop_run();
      enable = 1'b0; m_end = ((cyc - m_k) / FT) * FT + FT - 1;
   endtask

   task automatic wait_fs(input int bound, output longint at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge vga_clk);
         if (frame_start === 1'b1) begin
            at = cyc;
            break;
         end
      end
      cmp_cnt++;
      if (at < 0) begin
         err_cnt++;
         $display("FAIL wait_frame_start got timeout after %0d cycles want a pulse", bound);
      end
   endtask

   task automatic test_reset();
      #1 sys_rst = 1'b1;
      #1;
      cmp_cnt++;
      if ({hsync, vsync, rgb_valid, pix_req, frame_start, pix_x, pix_y, rgb_red, rgb_green, rgb_blue}
          !== {~HPOL, ~VPOL, 3'b000, 24'h0, 24'h0}) begin
         err_cnt++;
         $display("FAIL reset_values got hs=%b vs=%b de=%b req=%b fs=%b want hs=1 vs=1 rest 0",
                  hsync, vsync, rgb_valid, pix_req, frame_start);
      end
      repeat (3) @(negedge vga_clk);
      sys_rst = 1'b0;
      begin
         int reqs = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge vga_clk);
            if (pix_req === 1'b1 || hsync !== ~HPOL) reqs++;
         end
         cmp_cnt++;
         if (reqs != 0) begin
            err_cnt++;
            $display("FAIL idle_after_reset got %0d active cycles want 0", reqs);
         end
      end
   endtask

   task automatic test_timing();
      longint f, f2;
      int hs_lo = 0, vs_lo = 0, fs_n = 0, req_n = 0, de_n = 0, max_x = 0, max_y = 0;
      @(negedge vga_clk);
      start_run();
      wait_fs(FT + 10, f);
      cmp_cnt++;
      if (f != m_k + 2) begin
         err_cnt++;
         $display("FAIL start_latency got frame_start at %0d want %0d", f, m_k + 2);
      end
      for (int i = 0; i < FT; i++) begin
         if (i > 0) @(negedge vga_clk);
         if (hsync === HPOL) hs_lo++;
         if (vsync === VPOL) vs_lo++;
         if (frame_start === 1'b1) fs_n++;
         if (rgb_valid === 1'b1) de_n++;
         if (pix_req === 1'b1) begin
            req_n++;
            if (int'(pix_x) > max_x) max_x = int'(pix_x);
            if (int'(pix_y) > max_y) max_y = int'(pix_y);
         end
      end
      cmp_cnt++;
      if (hs_lo != H_SY * VT) begin err_cnt++; $display("FAIL hsync_low got %0d want %0d", hs_lo, H_SY * VT); end
      cmp_cnt++;
      if (vs_lo != V_SY * HT) begin err_cnt++; $display("FAIL vsync_low got %0d want %0d", vs_lo, V_SY * HT); end
      cmp_cnt++;
      if (fs_n != 1) begin err_cnt++; $display("FAIL fs_per_frame got %0d want 1", fs_n); end
      cmp_cnt++;
      if (req_n != H_AC * V_AC) begin err_cnt++; $display("FAIL req_count got %0d want %0d", req_n, H_AC * V_AC); end
      cmp_cnt++;
      if (de_n != H_AC * V_AC) begin err_cnt++; $display("FAIL de_count got %0d want %0d", de_n, H_AC * V_AC); end
      cmp_cnt++;
      if (max_x != H_AC - 1 || max_y != V_AC - 1) begin
         err_cnt++;
         $display("FAIL pix_range got x=%0d y=%0d want x=%0d y=%0d", max_x, max_y, H_AC - 1, V_AC - 1);
      end
      wait_fs(FT + 10, f2);
      cmp_cnt++;
      if (f2 != f + FT) begin err_cnt++; $display("FAIL fs_period got %0d want %0d", f2 - f, FT); end
   endtask

   task automatic test_stop();
      longint f;
      int de_n = 0, fs_n = 0;
      wait_fs(FT + 10, f);
      for (int i = 0; i < 2 * FT; i++) begin
         if (i > 0) @(negedge vga_clk);
         if (i == 2 * HT) drop_run();
         if (rgb_valid === 1'b1) de_n++;
         if (frame_start === 1'b1) fs_n++;
      end
      cmp_cnt++;
      if (de_n != H_AC * V_AC) begin err_cnt++; $display("FAIL stop_de_count got %0d want %0d", de_n, H_AC * V_AC); end
      cmp_cnt++;
      if (fs_n != 1) begin err_cnt++; $display("FAIL stop_fs_count got %0d want 1", fs_n); end
      cmp_cnt++;
      if ({hsync, vsync, pix_req} !== {~HPOL, ~VPOL, 1'b0}) begin
         err_cnt++;
         $display("FAIL stop_idle got hs=%b vs=%b req=%b want hs=1 vs=1 req=0", hsync, vsync, pix_req);
      end
   endtask

   task automatic test_resume();
      longint f0, f1, f2;
      @(negedge vga_clk);
      start_run();
      wait_fs(FT + 10, f0);
      repeat (2 * HT) @(negedge vga_clk);
      drop_run();
      repeat (3 * HT) @(negedge vga_clk);
      enable = 1'b1; m_end = INF;
      wait_fs(2 * FT, f1);
      cmp_cnt++;
      if (f1 != f0 + FT) begin err_cnt++; $display("FAIL resume_gap1 got %0d want %0d", f1 - f0, FT); end
      wait_fs(2 * FT, f2);
      cmp_cnt++;
      if (f2 != f0 + 2 * FT) begin err_cnt++; $display("FAIL resume_gap2 got %0d want %0d", f2 - f0, 2 * FT); end
      @(negedge vga_clk);
      drop_run();
      repeat (FT + 10) @(negedge vga_clk);
   endtask

   task automatic test_back_to_back();
      int act = 0;
      @(negedge vga_clk);
      start_run();
      for (int i = 0; i < 3 * FT && cyc < m_k + FT - 1; i++) @(negedge vga_clk);
      drop_run();
      for (int i = 0; i < FT + 5; i++) begin
         @(negedge vga_clk);
         if (pix_req === 1'b1 || frame_start === 1'b1) act++;
      end
      cmp_cnt++;
      if (act != 0) begin
         err_cnt++;
         $display("FAIL stop_on_last_pixel got %0d active cycles want 0", act);
      end
   endtask

   task automatic test_midreset();
      longint f;
      int act = 0;
      @(negedge vga_clk);
      start_run();
      wait_fs(FT + 10, f);
      for (int i = 0; i < FT && rgb_valid !== 1'b1; i++) @(negedge vga_clk);
      #1;
      sys_rst = 1'b1; enable = 1'b0; m_on = 1'b0;
      #1;
      exp_q.delete();
      cmp_cnt++;
      if ({hsync, vsync, rgb_valid, pix_req, frame_start, pix_x, rgb_red, rgb_green, rgb_blue}
          !== {~HPOL, ~VPOL, 3'b000, 12'h0, 24'h0}) begin
         err_cnt++;
         $display("FAIL async_reset got hs=%b vs=%b de=%b req=%b x=%0d rgb=%02h%02h%02h want idle",
                  hsync, vsync, rgb_valid, pix_req, pix_x, rgb_red, rgb_green, rgb_blue);
      end
      repeat (3) @(negedge vga_clk);
      sys_rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge vga_clk);
         if (pix_req === 1'b1 || frame_start === 1'b1 || hsync === HPOL) act++;
      end
      cmp_cnt++;
      if (act != 0) begin err_cnt++; $display("FAIL idle_until_enable got %0d active cycles want 0", act); end
      start_run();
      wait_fs(FT + 10, f);
      cmp_cnt++;
      if (f != m_k + 2) begin err_cnt++; $display("FAIL restart_latency got %0d want %0d", f, m_k + 2); end
      @(negedge vga_clk);
      drop_run();
      repeat (FT + 10) @(negedge vga_clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_timing();
      test_stop();
      test_resume();
      test_back_to_back();
      test_midreset();
      cmp_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL rgb_leftover got %0d queued want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
